// File: rtl/neuron_classifier_if.sv
// rtl/neuron_classifier_if.sv - control, sample and result signals of neuron_classifier
interface neuron_classifier_if #(
  parameter int XW = 7,
  parameter int WW = 14,
  parameter int CW = 32
);
  logic                 start;
  logic [CW-1:0]        nBus;
  logic signed [WW-1:0] W1;
  logic signed [WW-1:0] W2;
  logic signed [WW-1:0] Bias;
  logic signed [XW-1:0] X1Bus;
  logic signed [XW-1:0] X2Bus;
  logic [1:0]           tBus;
  logic                 sampleValid;
  logic                 sampleReady;
  logic [1:0]           y;
  logic                 yValid;
  logic                 match;
  logic [CW-1:0]        testCount;
  logic [CW-1:0]        errCount;
  logic                 busy;
  logic                 done;

  modport master (
    output start, nBus, W1, W2, Bias, X1Bus, X2Bus, tBus, sampleValid,
    input  sampleReady, y, yValid, match, testCount, errCount, busy, done
  );

  modport slave (
    input  start, nBus, W1, W2, Bias, X1Bus, X2Bus, tBus, sampleValid,
    output sampleReady, y, yValid, match, testCount, errCount, busy, done
  );
endinterface

// File: rtl/neuron_classifier.sv
// rtl/neuron_classifier.sv - two-stage hard-limit classifier with error counting
module neuron_classifier #(
  parameter int XW = 7,
  parameter int WW = 14,
  parameter int CW = 32
) (
  input  logic               clk,
  input  logic               rstN,
  neuron_classifier_if.slave bus
);
  localparam int PW = XW + WW;  // product width
  localparam int SW = PW + 2;   // sum width, wide enough that p1+p2+bias never overflows

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nx;
  logic signed [WW-1:0] w1_q, w2_q, bias_q;
  logic [CW-1:0]        n_q, accepted;
  logic signed [PW-1:0] p1, p2;
  logic                 t1_neg, v1;
  logic [1:0]           y_q;
  logic                 y_valid_q, match_q;
  logic [CW-1:0]        test_cnt, err_cnt;

  logic                 start_ok, ready, xfer, y_neg, match_nx;
  logic signed [PW-1:0] x1_ext, x2_ext, w1_ext, w2_ext;
  logic signed [SW-1:0] yin;
  wire                  unused_t0;

  // Only the sign bit of the target matters; bit 0 is always 1 for a valid target.
  assign unused_t0 = bus.tBus[0];

  // Handshake decode, operand sign extension and the stage-2 sum.
  always_comb begin
    start_ok = bus.start && (state == IDLE || state == DONE);
    ready    = (state == RUN) && (accepted < n_q);
    xfer     = bus.sampleValid && ready;
    x1_ext   = {{WW{bus.X1Bus[XW-1]}}, bus.X1Bus};
    x2_ext   = {{WW{bus.X2Bus[XW-1]}}, bus.X2Bus};
    w1_ext   = {{XW{w1_q[WW-1]}}, w1_q};
    w2_ext   = {{XW{w2_q[WW-1]}}, w2_q};
    yin      = {{2{p1[PW-1]}}, p1} + {{2{p2[PW-1]}}, p2}
             + {{(SW-WW){bias_q[WW-1]}}, bias_q};
    y_neg    = yin[SW-1];
    match_nx = (y_neg == t1_neg);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state: run until n samples accepted, then drain the pipeline.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nx = RUN;
      RUN:        if (accepted == n_q) state_nx = DRAIN;
      DRAIN:      if (!v1 && !y_valid_q) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Weight/length capture on an accepted start, and the accepted-sample count.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      w1_q     <= '0;
      w2_q     <= '0;
      bias_q   <= '0;
      n_q      <= '0;
      accepted <= '0;
    end else if (start_ok) begin
      w1_q     <= bus.W1;
      w2_q     <= bus.W2;
      bias_q   <= bus.Bias;
      n_q      <= bus.nBus;
      accepted <= '0;
    end else if (xfer) begin
      accepted <= accepted + CW'(1);
    end
  end

  // Stage 1: register both products and the target sign of each transfer.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      v1     <= 1'b0;
      p1     <= '0;
      p2     <= '0;
      t1_neg <= 1'b0;
    end else begin
      v1 <= xfer;
      if (xfer) begin
        p1     <= w1_ext * x1_ext;
        p2     <= w2_ext * x2_ext;
        t1_neg <= bus.tBus[1];
      end
    end
  end

  // Stage 2: hard-limit, compare with target and update saturating counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      y_valid_q <= 1'b0;
      y_q       <= 2'b01;
      match_q   <= 1'b0;
      test_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      y_valid_q <= v1;
      if (start_ok) begin
        test_cnt <= '0;
        err_cnt  <= '0;
      end else if (v1) begin
        y_q     <= y_neg ? 2'b11 : 2'b01;
        match_q <= match_nx;
        if (test_cnt != '1) test_cnt <= test_cnt + CW'(1);
        if (!match_nx && err_cnt != '1) err_cnt <= err_cnt + CW'(1);
      end
    end
  end

  assign bus.sampleReady = ready;
  assign bus.y           = y_q;
  assign bus.yValid      = y_valid_q;
  assign bus.match       = match_q;
  assign bus.testCount   = test_cnt;
  assign bus.errCount    = err_cnt;
  assign bus.busy        = (state == RUN) || (state == DRAIN);
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_neuron_classifier.sv
// tb/tb_neuron_classifier.sv - directed vectors checked against a behavioural classifier model
module tb_neuron_classifier;
  localparam int XW = 7;
  localparam int WW = 14;
  localparam int CW = 32;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  neuron_classifier_if #(.XW(XW), .WW(WW), .CW(CW)) bus ();
  neuron_classifier #(.XW(XW), .WW(WW), .CW(CW)) dut (.clk(clk), .rstN(rstN), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         due;
    logic [1:0] y;
    logic       m;
  } res_t;

  res_t       q[$];
  int         cyc = 0;
  bit         m_run = 0, m_started = 0;
  int         m_acc = 0, m_n = 0, m_w1 = 0, m_w2 = 0, m_b = 0;
  logic [1:0] m_y = 2'b01;
  logic       m_m = 1'b0;
  int         m_tc = 0, m_ec = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model_yin(input int w1, w2, b, x1, x2);
    return w1 * x1 + w2 * x2 + b;
  endfunction

  // Model plus per-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstN) begin
        q.delete();
        m_run = 0; m_started = 0; m_acc = 0; m_n = 0;
        m_y = 2'b01; m_m = 1'b0; m_tc = 0; m_ec = 0;
        check("rst_y", bus.y, 2'b01);
        check("rst_yValid", bus.yValid, 0);
        check("rst_match", bus.match, 0);
        check("rst_ready", bus.sampleReady, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_testCount", bus.testCount, 0);
        check("rst_errCount", bus.errCount, 0);
      end else begin
        bit   exp_v, mready, in_run;
        res_t r;
        int   yin;
        exp_v = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
          r = q.pop_front();
          exp_v = 1;
          m_y = r.y;
          m_m = r.m;
          m_tc++;
          if (!r.m) m_ec++;
        end
        check("yValid", bus.yValid, exp_v);
        check("y", bus.y, m_y);
        check("match", bus.match, m_m);
        check("testCount", bus.testCount, m_tc);
        check("errCount", bus.errCount, m_ec);
        mready = m_run && (m_acc < m_n);
        check("sampleReady", bus.sampleReady, mready);
        in_run = m_run && (m_acc < m_n || q.size() > 0 || exp_v);
        if (in_run) begin
          check("busy_in_run", bus.busy, 1);
          check("done_in_run", bus.done, 0);
        end else if (!m_started) begin
          check("busy_idle", bus.busy, 0);
          check("done_idle", bus.done, 0);
        end
        if (bus.start && !in_run) begin
          m_run = 1; m_started = 1; m_acc = 0; m_n = int'(bus.nBus);
          m_w1 = int'(bus.W1); m_w2 = int'(bus.W2); m_b = int'(bus.Bias);
          m_tc = 0; m_ec = 0;
        end else if (bus.sampleValid && mready) begin
          yin = model_yin(m_w1, m_w2, m_b, int'(bus.X1Bus), int'(bus.X2Bus));
          r.due = cyc + 2;
          r.y = (yin >= 0) ? 2'b01 : 2'b11;
          r.m = ((yin < 0) == bus.tBus[1]);
          q.push_back(r);
          m_acc++;
        end
      end
    end
  end

  task automatic do_start(input int n, input int w1, input int w2, input int b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.nBus  = CW'(n);
    bus.W1    = WW'(w1);
    bus.W2    = WW'(w2);
    bus.Bias  = WW'(b);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input int x1, input int x2, input bit neg);
    bus.X1Bus = XW'(x1);
    bus.X2Bus = XW'(x2);
    bus.tBus  = neg ? 2'b11 : 2'b01;
    bus.sampleValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sampleReady) break;
    end
    check("send_ready", bus.sampleReady, 1);
    @(posedge clk); #1;
    bus.sampleValid = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_reached", bus.done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 0; bus.nBus = '0; bus.W1 = '0; bus.W2 = '0; bus.Bias = '0;
    bus.X1Bus = '0; bus.X2Bus = '0; bus.tBus = 2'b01; bus.sampleValid = 0;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // 1: single sample, yin = 0 classifies as +1
    check("model_yin_t1", model_yin(2, 3, -5, 1, 1), 0);
    do_start(1, 2, 3, -5);
    send(1, 1, 0);
    wait_done(20);
    check("t1_y", bus.y, 2'b01);
    check("t1_match", bus.match, 1);
    check("t1_errCount", bus.errCount, 0);

    // 2: back-to-back pair, first one misclassified against its target
    do_start(2, 2, 3, -5);
    send(-1, 1, 0);
    send(3, 0, 0);
    wait_done(20);
    check("t2_testCount", bus.testCount, 2);
    check("t2_errCount", bus.errCount, 1);
    check("t2_y", bus.y, 2'b01);

    // 3: extreme weights and samples
    check("model_yin_max", model_yin(8191, 8191, 8191, 63, 63), 1040257);
    check("model_yin_min", model_yin(-8192, -8192, -8192, 63, 63), -1040384);
    do_start(1, 8191, 8191, 8191);
    send(63, 63, 0);
    wait_done(20);
    check("t3_y_max", bus.y, 2'b01);
    do_start(1, -8192, -8192, -8192);
    send(63, 63, 1);
    wait_done(20);
    check("t3_y_min", bus.y, 2'b11);
    check("t3_match_min", bus.match, 1);

    // 4: valid pattern 1,0,1,1,0,1 with weights changed after start
    do_start(4, 1, 1, 0);
    bus.W1 = -14'sd100; bus.W2 = 14'sd77; bus.Bias = -14'sd3000;
    send(5, -3, 0);
    gap();
    send(-2, 1, 1);
    send(0, 0, 1);
    gap();
    send(-7, 3, 0);
    bus.X1Bus = 7'sd9; bus.X2Bus = 7'sd9; bus.sampleValid = 1'b1;
    @(negedge clk);
    check("t4_ready_after_4th", bus.sampleReady, 0);
    repeat (3) @(posedge clk);
    #1 bus.sampleValid = 1'b0;
    wait_done(20);
    check("t4_testCount", bus.testCount, 4);
    check("t4_errCount", bus.errCount, 2);

    // 5: n = 0, then start pulsed mid-run is ignored
    do_start(0, 2, 3, -5);
    wait_done(3);
    check("t5_testCount_n0", bus.testCount, 0);
    do_start(2, 2, 3, -5);
    send(1, 1, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.nBus = CW'(9); bus.W1 = 14'sd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    send(-1, 1, 1);
    wait_done(20);
    check("t5_testCount", bus.testCount, 2);
    check("t5_errCount", bus.errCount, 0);

    // 6: reset with two samples in flight, then a fresh run
    do_start(4, 1, 1, 0);
    send(1, 1, 0);
    send(-1, -1, 1);
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_yValid", bus.yValid, 0);
    check("t6_idle_busy", bus.busy, 0);
    do_start(1, 2, 3, -5);
    send(3, 0, 0);
    wait_done(20);
    check("t6_testCount", bus.testCount, 1);
    check("t6_errCount", bus.errCount, 0);
    check("t6_y", bus.y, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
